// File: rtl/anffl_mem_rd_responder_if.sv
// Memory read port between a client (TEX etc.) and the read responder.
// ANFFL_MEM_RD_RANGE_ERR_EN adds mem_rd_err to the response side.
interface anffl_mem_rd_responder_if;
    logic        mem_rd_req;
    logic [31:0] mem_rd_addr;
    logic [1:0]  mem_rd_len;
    logic        mem_rd_ready;
    logic        mem_rd_valid;
    logic [31:0] mem_rd_data;
    logic        mem_rd_last;
    logic        mem_rd_accept;
`ifdef ANFFL_MEM_RD_RANGE_ERR_EN
    logic        mem_rd_err;

    modport master (
        output mem_rd_req, mem_rd_addr, mem_rd_len, mem_rd_accept,
        input  mem_rd_ready, mem_rd_valid, mem_rd_data, mem_rd_last, mem_rd_err
    );
    modport slave (
        input  mem_rd_req, mem_rd_addr, mem_rd_len, mem_rd_accept,
        output mem_rd_ready, mem_rd_valid, mem_rd_data, mem_rd_last, mem_rd_err
    );
`else
    modport master (
        output mem_rd_req, mem_rd_addr, mem_rd_len, mem_rd_accept,
        input  mem_rd_ready, mem_rd_valid, mem_rd_data, mem_rd_last
    );
    modport slave (
        input  mem_rd_req, mem_rd_addr, mem_rd_len, mem_rd_accept,
        output mem_rd_ready, mem_rd_valid, mem_rd_data, mem_rd_last
    );
`endif
endinterface

// File: rtl/anffl_mem_rd_responder.sv
// Memory-read responder: 1-4 word bursts from a fixed-latency SRAM, credit-throttled FIFO.
// Optional ANFFL_MEM_RD_RANGE_ERR_EN: out-of-range requests return zero beats flagged mem_rd_err.
module anffl_mem_rd_responder #(
    parameter int unsigned ADDR_W    = 14,
    parameter int unsigned SRAM_LAT  = 2,
    parameter int unsigned BUF_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    anffl_mem_rd_responder_if.slave memRd,
    output logic                  sram_en,
    output logic [ADDR_W-1:0]     sram_addr,
    input  logic [31:0]           sram_rdata
);
    localparam int unsigned PTR_W = $clog2(BUF_DEPTH);
    localparam int unsigned CNT_W = $clog2(BUF_DEPTH + 1);
    localparam int unsigned OCC_W = $clog2(BUF_DEPTH + SRAM_LAT + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} stateT;
    stateT state, stateNext;

    logic                readyQ;
    logic [ADDR_W-1:0]   baseQ;
    logic [1:0]          lenQ;
    logic                errQ;
    logic [1:0]          issueCnt;
    logic [1:0]          retireCnt;
    logic [SRAM_LAT-1:0] tagPipe;

    logic [31:0]         fifoMem [BUF_DEPTH];
    logic [PTR_W-1:0]    wrPtr, rdPtr;
    logic [CNT_W-1:0]    fifoCount;

    logic                reqTaken, retire, issue, push, rangeErr, hasCredit, headValid;
    logic [OCC_W-1:0]    inFlight, occupancy;
    logic [31:0]         pushData;
    logic                unusedAddrBits;

    function automatic logic [PTR_W-1:0] ptrInc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(BUF_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign reqTaken = memRd.mem_rd_req & readyQ;
    assign headValid = (fifoCount != '0);
    assign retire = headValid & memRd.mem_rd_accept;
    assign unusedAddrBits = ^{memRd.mem_rd_addr[1:0], memRd.mem_rd_addr[31:ADDR_W+2]};

`ifdef ANFFL_MEM_RD_RANGE_ERR_EN
    assign rangeErr = |memRd.mem_rd_addr[31:ADDR_W+2];
    assign memRd.mem_rd_err = headValid & errQ;
`else
    assign rangeErr = 1'b0;
`endif

    // Credit counts FIFO entries plus reads still in the SRAM pipe so a return always has a slot.
    always_comb begin
        inFlight = '0;
        for (int unsigned i = 0; i < SRAM_LAT; i++) begin
            inFlight = inFlight + OCC_W'(tagPipe[i]);
        end
        occupancy = OCC_W'(fifoCount) + inFlight;
        hasCredit = (occupancy < OCC_W'(BUF_DEPTH));
    end

    always_comb begin
        stateNext = state;
        issue     = 1'b0;
        case (state)
            IDLE: begin
                if (reqTaken) stateNext = ISSUE;
            end
            ISSUE: begin
                issue = hasCredit;
                if (issue && issueCnt == lenQ) stateNext = DRAIN;
            end
            DRAIN: begin
                if (retire && retireCnt == lenQ) stateNext = IDLE;
            end
            default: stateNext = IDLE;
        endcase
    end

    assign sram_en   = issue & ~errQ;
    assign sram_addr = baseQ + ADDR_W'(issueCnt);
    assign push      = tagPipe[SRAM_LAT-1] | (issue & errQ);
    assign pushData  = errQ ? '0 : sram_rdata;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            readyQ    <= 1'b0;
            baseQ     <= '0;
            lenQ      <= '0;
            errQ      <= 1'b0;
            issueCnt  <= '0;
            retireCnt <= '0;
            tagPipe   <= '0;
            wrPtr     <= '0;
            rdPtr     <= '0;
            fifoCount <= '0;
        end else begin
            state  <= stateNext;
            readyQ <= (stateNext == IDLE);
            if (reqTaken) begin
                baseQ     <= memRd.mem_rd_addr[ADDR_W+1:2];
                lenQ      <= memRd.mem_rd_len;
                errQ      <= rangeErr;
                issueCnt  <= '0;
                retireCnt <= '0;
            end else begin
                if (issue)  issueCnt  <= issueCnt + 1'b1;
                if (retire) retireCnt <= retireCnt + 1'b1;
            end
            tagPipe[0] <= sram_en;
            for (int unsigned i = 1; i < SRAM_LAT; i++) begin
                tagPipe[i] <= tagPipe[i-1];
            end
            if (push)   wrPtr <= ptrInc(wrPtr);
            if (retire) rdPtr <= ptrInc(rdPtr);
            case ({push, retire})
                2'b10:   fifoCount <= fifoCount + 1'b1;
                2'b01:   fifoCount <= fifoCount - 1'b1;
                default: fifoCount <= fifoCount;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) fifoMem[wrPtr] <= pushData;
    end

    assign memRd.mem_rd_ready = readyQ;
    assign memRd.mem_rd_valid = headValid;
    assign memRd.mem_rd_data  = headValid ? fifoMem[rdPtr] : '0;
    assign memRd.mem_rd_last  = headValid & (retireCnt == lenQ);
endmodule

// File: tb/tb_anffl_mem_rd_responder.sv
// Scoreboard bench for anffl_mem_rd_responder with a behavioural fixed-latency SRAM.
// Build with ANFFL_MEM_RD_RANGE_ERR_EN defined to also cover the range-error responses.
module tb_anffl_mem_rd_responder;
    localparam int unsigned ADDR_W    = 14;
    localparam int unsigned SRAM_LAT  = 2;
    localparam int unsigned BUF_DEPTH = 4;

    typedef struct packed {
        logic [31:0] data;
        logic        last;
        logic        err;
    } beatT;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    anffl_mem_rd_responder_if bus();
    logic              sramEn;
    logic [ADDR_W-1:0] sramAddr;
    logic [31:0]       sramRdata;

    anffl_mem_rd_responder #(
        .ADDR_W(ADDR_W),
        .SRAM_LAT(SRAM_LAT),
        .BUF_DEPTH(BUF_DEPTH)
    ) dut (
        .clk(clk),
        .reset(reset),
        .memRd(bus),
        .sram_en(sramEn),
        .sram_addr(sramAddr),
        .sram_rdata(sramRdata)
    );

    logic [31:0] sramMem [2**ADDR_W];
    logic [31:0] rdPipe  [SRAM_LAT];
    always @(posedge clk) begin
        rdPipe[0] <= sramEn ? sramMem[sramAddr] : 32'hBAD0_BAD0;
        for (int i = 1; i < SRAM_LAT; i++) rdPipe[i] <= rdPipe[i-1];
    end
    assign sramRdata = rdPipe[SRAM_LAT-1];

    beatT              expQ[$];
    logic [ADDR_W-1:0] expAddrQ[$];
    int unsigned       nCompared = 0;
    int unsigned       nMismatched = 0;

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nCompared++;
        if (obs !== exp) begin
            nMismatched++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    logic        prevHeld = 1'b0;
    logic [31:0] prevData;
    logic        prevLast;
    logic        expectReady = 1'b0;
    beatT        gotBeat;

    always @(negedge clk) begin
        if (reset) begin
            prevHeld    = 1'b0;
            expectReady = 1'b0;
        end else begin
            if (expectReady) checkVal("readyBack", bus.mem_rd_ready, 1);
            expectReady = 1'b0;
            if (prevHeld) begin
                checkVal("holdValid", bus.mem_rd_valid, 1);
                checkVal("holdData", bus.mem_rd_data, prevData);
                checkVal("holdLast", bus.mem_rd_last, prevLast);
            end
            if (sramEn) begin
                if (expAddrQ.size() == 0) checkVal("sramStray", 1, 0);
                else checkVal("sramAddr", sramAddr, expAddrQ.pop_front());
            end
            if (bus.mem_rd_valid) begin
                checkVal("readyInBurst", bus.mem_rd_ready, 0);
                if (bus.mem_rd_accept) begin
                    if (expQ.size() == 0) checkVal("strayBeat", 1, 0);
                    else begin
                        gotBeat = expQ.pop_front();
                        checkVal("beatData", bus.mem_rd_data, gotBeat.data);
                        checkVal("beatLast", bus.mem_rd_last, gotBeat.last);
`ifdef ANFFL_MEM_RD_RANGE_ERR_EN
                        checkVal("beatErr", bus.mem_rd_err, gotBeat.err);
`endif
                        if (gotBeat.last) expectReady = 1'b1;
                    end
                end
            end
            prevHeld = bus.mem_rd_valid & ~bus.mem_rd_accept;
            prevData = bus.mem_rd_data;
            prevLast = bus.mem_rd_last;
        end
    end

    logic randAccept = 1'b0;
    always @(posedge clk) begin
        if (randAccept) begin
            #1;
            bus.mem_rd_accept = ($urandom_range(0, 3) != 0);
        end
    end

    task automatic doRead(input logic [31:0] addr, input logic [1:0] len);
        int unsigned       n;
        logic              isErr;
        logic [ADDR_W-1:0] base;
        logic [ADDR_W-1:0] a;
        n = 0;
        @(negedge clk);
        while (!bus.mem_rd_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!bus.mem_rd_ready) checkVal("reqReadyTimeout", 0, 1);
`ifdef ANFFL_MEM_RD_RANGE_ERR_EN
        isErr = (addr[31:ADDR_W+2] != '0);
`else
        isErr = 1'b0;
`endif
        base = addr[ADDR_W+1:2];
        for (int unsigned i = 0; i <= 32'(len); i++) begin
            a = base + ADDR_W'(i);
            if (isErr) expQ.push_back('{data: 32'h0, last: (i == 32'(len)), err: 1'b1});
            else begin
                expAddrQ.push_back(a);
                expQ.push_back('{data: sramMem[a], last: (i == 32'(len)), err: 1'b0});
            end
        end
        bus.mem_rd_req  = 1'b1;
        bus.mem_rd_addr = addr;
        bus.mem_rd_len  = len;
        @(posedge clk);
        #1;
        bus.mem_rd_req  = 1'b0;
        bus.mem_rd_addr = '0;
        bus.mem_rd_len  = '0;
    endtask

    task automatic waitIdle(output int unsigned sramSeen);
        int unsigned n;
        n = 0;
        sramSeen = 0;
        do begin
            @(negedge clk);
            if (sramEn) sramSeen++;
            n++;
        end while (!(expQ.size() == 0 && bus.mem_rd_ready) && n < 200);
        if (!(expQ.size() == 0 && bus.mem_rd_ready)) checkVal("idleTimeout", 0, 1);
    endtask

    task automatic waitValid();
        int unsigned n;
        n = 0;
        @(negedge clk);
        while (!bus.mem_rd_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!bus.mem_rd_valid) checkVal("validTimeout", 0, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned seen;
        int unsigned n;
        int unsigned issued;
        bus.mem_rd_req    = 1'b0;
        bus.mem_rd_addr   = '0;
        bus.mem_rd_len    = '0;
        bus.mem_rd_accept = 1'b1;
        for (int i = 0; i < 2**ADDR_W; i++) sramMem[i] = 32'h5A00_0000 ^ i;
        sramMem[14'h0010] = 32'hDEAD_BEEF;
        sramMem[14'h0020] = 32'd1;
        sramMem[14'h0021] = 32'd2;
        sramMem[14'h0022] = 32'd3;
        sramMem[14'h0023] = 32'd4;
        sramMem[14'h3FFE] = 32'hA000_3FFE;
        sramMem[14'h3FFF] = 32'hA000_3FFF;
        sramMem[14'h0000] = 32'hA000_0000;
        sramMem[14'h0001] = 32'hA000_0001;

        // Reset values
        #22;
        checkVal("rstReady", bus.mem_rd_ready, 0);
        checkVal("rstValid", bus.mem_rd_valid, 0);
        checkVal("rstData", bus.mem_rd_data, 0);
        checkVal("rstLast", bus.mem_rd_last, 0);
        checkVal("rstSramEn", sramEn, 0);
        checkVal("rstSramAddr", sramAddr, 0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checkVal("readyAfterReset", bus.mem_rd_ready, 1);

        // Single read and first-beat latency
        doRead(32'h0000_0040, 2'd0);
        n = 0;
        while (n < 20) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (bus.mem_rd_valid) break;
        end
        checkVal("latency", n, SRAM_LAT + 1);
        waitIdle(seen);

        // Four-beat burst on consecutive cycles
        doRead(32'h0000_0080, 2'd3);
        waitValid();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkVal("beatStream", bus.mem_rd_valid, 1);
        end
        @(negedge clk);
        checkVal("burstEnd", bus.mem_rd_valid, 0);
        waitIdle(seen);

        // Backpressure: client stalls for six cycles
        bus.mem_rd_accept = 1'b0;
        doRead(32'h0000_0080, 2'd3);
        issued = 0;
        repeat (6) begin
            @(negedge clk);
            if (sramEn) issued++;
        end
        checkVal("stallIssues", issued, BUF_DEPTH);
        checkVal("stallValid", bus.mem_rd_valid, 1);
        checkVal("stallHeadData", bus.mem_rd_data, 32'd1);
        @(posedge clk);
        #1;
        bus.mem_rd_accept = 1'b1;
        waitIdle(seen);

        // Wrap past the top SRAM word
        doRead((32'(2**ADDR_W) - 32'd2) * 32'd4, 2'd3);
        waitIdle(seen);
`ifndef ANFFL_MEM_RD_RANGE_ERR_EN
        doRead(32'h0010_0040, 2'd0);
        waitIdle(seen);
        checkVal("upperIgnoredSram", seen, 1);
`endif

        // Random bursts with random backpressure
        randAccept = 1'b1;
        for (int i = 0; i < 8; i++) begin
            doRead($urandom & 32'h0000_FFFC, 2'($urandom_range(0, 3)));
        end
        randAccept = 1'b0;
        @(posedge clk);
        #2;
        bus.mem_rd_accept = 1'b1;
        waitIdle(seen);

        // Reset while beat 2 of 4 is pending
        bus.mem_rd_accept = 1'b0;
        doRead(32'h0000_0080, 2'd3);
        waitValid();
        @(posedge clk);
        #1;
        bus.mem_rd_accept = 1'b1;
        @(posedge clk);
        #1;
        bus.mem_rd_accept = 1'b0;
        @(negedge clk);
        #3;
        reset = 1'b1;
        #1;
        checkVal("midRstValid", bus.mem_rd_valid, 0);
        checkVal("midRstSramEn", sramEn, 0);
        checkVal("midRstReady", bus.mem_rd_ready, 0);
        expQ.delete();
        expAddrQ.delete();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        bus.mem_rd_accept = 1'b1;
        @(negedge clk);
        checkVal("readyAfterMidRst", bus.mem_rd_ready, 1);
        repeat (8) begin
            @(negedge clk);
            checkVal("noStrayValid", bus.mem_rd_valid, 0);
        end

`ifdef ANFFL_MEM_RD_RANGE_ERR_EN
        // Out-of-range request: zero beats flagged err, no SRAM access
        doRead(32'h0010_0000, 2'd1);
        waitIdle(seen);
        checkVal("errNoSram", seen, 0);
`endif

        // Normal read still works afterwards
        doRead(32'h0000_0040, 2'd0);
        waitIdle(seen);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end
endmodule
